// File: rtl/pixel_frame_sequencer.sv
// -----------------------------------------------------------------------------
// pixel_frame_sequencer
//
// Frame-level controller for a 2x2 pixel array. A start request runs one
// capture: erase -> expose -> ramp conversion -> readout of pixel pairs 1/2
// and 3/4. The four captured bytes are serialised onto a valid/ready stream
// in the order p1, p2, p3, p4. All outputs are registered.
//
// Optional feature (compile-time macro):
//   PIX_GRAY_CODE_EN  - adc_code is the Gray code of the internal binary ramp
//                       counter; undefined -> adc_code is plain binary.
//
// Ports:
//   clk          in   1         system clock, rising edge
//   reset        in   1         asynchronous active-low reset
//   start        in   1         begin one frame, sampled only in IDLE
//   abort        in   1         synchronous abort of the current frame
//   exp_cycles   in   EXP_W     exposure length in cycles (0 treated as 1)
//   pix_data_in  in   2*DATA_W  array read bus {pixB, pixA}
//   erase        out  1         array erase strobe
//   expose       out  1         array expose strobe
//   convert      out  1         array convert strobe (ramp running)
//   read12       out  1         array read enable, pixels 1 and 2
//   read34       out  1         array read enable, pixels 3 and 4
//   adc_code     out  DATA_W    ramp code driven to array comparators
//   out_data     out  DATA_W    serialised pixel byte
//   out_valid    out  1         out_data valid
//   out_ready    in   1         downstream accepts out_data
//   busy         out  1         high in every state except IDLE
//   frame_done   out  1         one-cycle pulse on frame completion
// -----------------------------------------------------------------------------
module pixel_frame_sequencer #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned EXP_W        = 16,
    parameter int unsigned ERASE_CYCLES = 4,
    parameter int unsigned SETTLE       = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [EXP_W-1:0]      exp_cycles,
    input  logic [2*DATA_W-1:0]   pix_data_in,
    output logic                  erase,
    output logic                  expose,
    output logic                  convert,
    output logic                  read12,
    output logic                  read34,
    output logic [DATA_W-1:0]     adc_code,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned ER_W  = $clog2(ERASE_CYCLES + 1);
    localparam int unsigned ST_W  = $clog2(SETTLE + 1);
    localparam int unsigned MX_W  = (ER_W > ST_W) ? ER_W : ST_W;
    localparam int unsigned CNT_W = (EXP_W > MX_W) ? EXP_W : MX_W;

    localparam logic [CNT_W-1:0] ERASE_LAST  = CNT_W'(ERASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_READ12,
        S_READ34,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [EXP_W-1:0]       exp_q, exp_d;
    logic [DATA_W-1:0]      bin_q, bin_d;
    logic [2*DATA_W-1:0]    buf_q, buf_d;
    logic                   cap_q, cap_d;     // pair captured, bytes pending
    logic                   sel_q, sel_d;     // 0: pixA on the bus, 1: pixB
    logic                   valid_q, valid_d;
    logic [DATA_W-1:0]      data_q, data_d;

    logic                   erase_q, erase_d;
    logic                   expose_q, expose_d;
    logic                   convert_q, convert_d;
    logic                   r12_q, r12_d;
    logic                   r34_q, r34_d;
    logic [DATA_W-1:0]      adc_q, adc_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            exp_q     <= '0;
            bin_q     <= '0;
            buf_q     <= '0;
            cap_q     <= 1'b0;
            sel_q     <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            erase_q   <= 1'b0;
            expose_q  <= 1'b0;
            convert_q <= 1'b0;
            r12_q     <= 1'b0;
            r34_q     <= 1'b0;
            adc_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            exp_q     <= exp_d;
            bin_q     <= bin_d;
            buf_q     <= buf_d;
            cap_q     <= cap_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            erase_q   <= erase_d;
            expose_q  <= expose_d;
            convert_q <= convert_d;
            r12_q     <= r12_d;
            r34_q     <= r34_d;
            adc_q     <= adc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        bin_d   = bin_q;
        buf_d   = buf_q;
        cap_d   = cap_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        data_d  = data_q;

        if (state_q != S_IDLE && abort) begin
            // Abort wins over everything, including a pending handshake.
            state_d = S_IDLE;
            cnt_d   = '0;
            bin_d   = '0;
            buf_d   = '0;
            cap_d   = 1'b0;
            sel_d   = 1'b0;
            valid_d = 1'b0;
            data_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_d = S_ERASE;
                        cnt_d   = '0;
                        exp_d   = (exp_cycles == '0) ? EXP_W'(1) : exp_cycles;
                    end
                end
                S_ERASE: begin
                    if (cnt_q == ERASE_LAST) begin
                        state_d = S_EXPOSE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_EXPOSE: begin
                    if (cnt_q == CNT_W'(exp_q - EXP_W'(1))) begin
                        state_d = S_CONVERT;
                        cnt_d   = '0;
                        bin_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_CONVERT: begin
                    // Leave at full scale instead of wrapping the ramp.
                    if (bin_q == '1) begin
                        state_d = S_READ12;
                        bin_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        bin_d = bin_q + DATA_W'(1);
                    end
                end
                S_READ12, S_READ34: begin
                    if (!cap_q) begin
                        if (cnt_q == SETTLE_LAST) begin
                            buf_d   = pix_data_in;
                            cap_d   = 1'b1;
                            sel_d   = 1'b0;
                            valid_d = 1'b1;
                            data_d  = pix_data_in[DATA_W-1:0];
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (out_ready) begin
                        if (!sel_q) begin
                            sel_d  = 1'b1;
                            data_d = buf_q[2*DATA_W-1:DATA_W];
                        end else begin
                            valid_d = 1'b0;
                            data_d  = '0;
                            cap_d   = 1'b0;
                            sel_d   = 1'b0;
                            cnt_d   = '0;
                            buf_d   = '0;
                            state_d = (state_q == S_READ12) ? S_READ34 : S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Outputs are decoded from the next state so they are registered
        // yet line up with the state they belong to.
        erase_d   = (state_d == S_ERASE);
        expose_d  = (state_d == S_EXPOSE);
        convert_d = (state_d == S_CONVERT);
        r12_d     = (state_d == S_READ12);
        r34_d     = (state_d == S_READ34);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        adc_d     = '0;
        if (state_d == S_CONVERT) begin
`ifdef PIX_GRAY_CODE_EN
            adc_d = bin_d ^ (bin_d >> 1);
`else
            adc_d = bin_d;
`endif
        end
    end

    assign erase      = erase_q;
    assign expose     = expose_q;
    assign convert    = convert_q;
    assign read12     = r12_q;
    assign read34     = r34_q;
    assign adc_code   = adc_q;
    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule
